// File: rtl/rvc_asap_eot_monitor.sv
// rvc_asap end-of-test monitor.
// Watches the executed-instruction stream of each hart. Each hart ends in
// PASS/FAIL (ebreak/ecall with a0 == 0 / != 0) or HUNG (same PC for too long).
// A global cycle timeout ends the test if some hart never finishes.
// Once the test is done, the monitor freezes until reset.
module rvc_asap_eot_monitor #(
  parameter int unsigned NUM_HARTS      = 1,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned HANG_CYCLES    = 256,
  parameter logic [31:0] EBREAK_OP      = 32'h00100073,
  parameter logic [31:0] ECALL_OP       = 32'h00000073
) (
  input  logic                      Clock,
  input  logic                      Rst,
  input  logic                      Enable,
  input  logic [NUM_HARTS-1:0]      InstValid,
  input  logic [32*NUM_HARTS-1:0]   Instruction,
  input  logic [32*NUM_HARTS-1:0]   Pc,
  input  logic [32*NUM_HARTS-1:0]   A0,
  output logic [2*NUM_HARTS-1:0]    HartStatus,
  output logic [NUM_HARTS-1:0]      HartDone,
  output logic [32*NUM_HARTS-1:0]   RetiredCnt,
  output logic [CNT_W-1:0]          CycleCnt,
  output logic                      TestDone,
  output logic                      TestPass,
  output logic                      TestTimeout
);

  // Hang counter must be able to hold HANG_CYCLES-1.
  localparam int unsigned          HW          = $clog2(HANG_CYCLES + 1);
  localparam logic [HW-1:0]        HANG_LAST   = HW'(HANG_CYCLES - 1);
  localparam logic [CNT_W-1:0]     TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]     CYC_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10,
    ST_HUNG = 2'b11
  } state_e;

  state_e            state_q     [NUM_HARTS];
  state_e            state_d     [NUM_HARTS];
  logic [31:0]       last_pc_q   [NUM_HARTS];
  logic [31:0]       last_pc_d   [NUM_HARTS];
  logic              have_pc_q   [NUM_HARTS];
  logic              have_pc_d   [NUM_HARTS];
  logic [HW-1:0]     hang_cnt_q  [NUM_HARTS];
  logic [HW-1:0]     hang_cnt_d  [NUM_HARTS];
  logic [31:0]       retired_q   [NUM_HARTS];
  logic [31:0]       retired_d   [NUM_HARTS];
  logic [NUM_HARTS-1:0] hart_done_q;
  logic [NUM_HARTS-1:0] hart_done_d;
  logic [CNT_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  cycle_d;
  logic              done_q;
  logic              done_d;
  logic              pass_q;
  logic              pass_d;
  logic              timeout_q;
  logic              timeout_d;

  // Next-state logic: per-hart FSMs, hang tracking, retire and cycle counters, verdict.
  always_comb begin
    logic [31:0]   ins_s;
    logic [31:0]   pc_s;
    logic [31:0]   a0_s;
    logic          term_s;
    logic          repeat_s;
    logic [HW-1:0] cnt_inc_s;
    logic          all_done_s;
    logic          all_pass_s;

    ins_s      = 32'd0;
    pc_s       = 32'd0;
    a0_s       = 32'd0;
    term_s     = 1'b0;
    repeat_s   = 1'b0;
    cnt_inc_s  = '0;
    all_done_s = 1'b1;
    all_pass_s = 1'b1;

    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      state_d[h]    = state_q[h];
      last_pc_d[h]  = last_pc_q[h];
      have_pc_d[h]  = have_pc_q[h];
      hang_cnt_d[h] = hang_cnt_q[h];
      retired_d[h]  = retired_q[h];
    end
    cycle_d   = cycle_q;
    done_d    = done_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;

    if (Enable && !done_q) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        ins_s     = Instruction[32*h +: 32];
        pc_s      = Pc[32*h +: 32];
        a0_s      = A0[32*h +: 32];
        term_s    = (ins_s == EBREAK_OP) || (ins_s == ECALL_OP);
        // The first valid PC after reset never counts as a repeat.
        repeat_s  = have_pc_q[h] && (pc_s == last_pc_q[h]);
        cnt_inc_s = hang_cnt_q[h] + HW'(1);

        if ((state_q[h] == ST_RUN) && InstValid[h]) begin
          if (retired_q[h] != 32'hFFFF_FFFF) begin
            retired_d[h] = retired_q[h] + 32'd1;
          end else begin
            retired_d[h] = retired_q[h];
          end

          if (repeat_s) begin
            hang_cnt_d[h] = cnt_inc_s;
          end else begin
            hang_cnt_d[h] = '0;
            last_pc_d[h]  = pc_s;
            have_pc_d[h]  = 1'b1;
          end

          // A terminating opcode wins over the hang threshold.
          if (term_s) begin
            state_d[h] = (a0_s == 32'd0) ? ST_PASS : ST_FAIL;
          end else if (repeat_s && (cnt_inc_s == HANG_LAST)) begin
            state_d[h] = ST_HUNG;
          end else begin
            state_d[h] = state_q[h];
          end
        end else begin
          state_d[h] = state_q[h];
        end
      end

      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        if (state_d[h] == ST_RUN) begin
          all_done_s = 1'b0;
        end else begin
          all_done_s = all_done_s;
        end
        if (state_d[h] != ST_PASS) begin
          all_pass_s = 1'b0;
        end else begin
          all_pass_s = all_pass_s;
        end
      end

      if (cycle_q != CYC_MAX) begin
        cycle_d = cycle_q + CNT_W'(1);
      end else begin
        cycle_d = cycle_q;
      end

      // Termination of the last hart on the timeout edge beats the timeout.
      timeout_d = (cycle_d == TIMEOUT_VAL) && !all_done_s;
      done_d    = all_done_s || timeout_d;
      pass_d    = all_done_s && all_pass_s && !timeout_d;
    end else begin
      done_d = done_q;
    end

    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      hart_done_d[h] = (state_d[h] != ST_RUN);
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        state_q[h]    <= ST_RUN;
        last_pc_q[h]  <= 32'd0;
        have_pc_q[h]  <= 1'b0;
        hang_cnt_q[h] <= '0;
        retired_q[h]  <= 32'd0;
      end
      hart_done_q <= '0;
      cycle_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
        state_q[h]    <= state_d[h];
        last_pc_q[h]  <= last_pc_d[h];
        have_pc_q[h]  <= have_pc_d[h];
        hang_cnt_q[h] <= hang_cnt_d[h];
        retired_q[h]  <= retired_d[h];
      end
      hart_done_q <= hart_done_d;
      cycle_q     <= cycle_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  // Pack per-hart registers onto the output buses.
  always_comb begin
    HartStatus = '0;
    RetiredCnt = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      HartStatus[2*h +: 2]  = state_q[h];
      RetiredCnt[32*h +: 32] = retired_q[h];
    end
  end

  assign HartDone    = hart_done_q;
  assign CycleCnt    = cycle_q;
  assign TestDone    = done_q;
  assign TestPass    = pass_q;
  assign TestTimeout = timeout_q;

endmodule

// File: tb/tb_rvc_asap_eot_monitor.sv
// Directed bench for rvc_asap_eot_monitor: two harts, hang threshold 4,
// timeout 50 cycles. Expected values are hand-computed per scenario.
module tb_rvc_asap_eot_monitor;

  localparam int unsigned NH = 2;
  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic            Clock = 1'b0;
  logic            Rst = 1'b1;
  logic            Enable = 1'b1;
  logic [NH-1:0]   InstValid = '0;
  logic [32*NH-1:0] Instruction = '0;
  logic [32*NH-1:0] Pc = '0;
  logic [32*NH-1:0] A0 = '0;
  logic [2*NH-1:0] HartStatus;
  logic [NH-1:0]   HartDone;
  logic [32*NH-1:0] RetiredCnt;
  logic [31:0]     CycleCnt;
  logic            TestDone;
  logic            TestPass;
  logic            TestTimeout;

  int n_checks = 0;
  int n_fail   = 0;

  rvc_asap_eot_monitor #(
    .NUM_HARTS(NH), .CNT_W(32), .TIMEOUT_CYCLES(50), .HANG_CYCLES(4),
    .EBREAK_OP(EBREAK), .ECALL_OP(ECALL)
  ) dut (
    .Clock(Clock), .Rst(Rst), .Enable(Enable), .InstValid(InstValid),
    .Instruction(Instruction), .Pc(Pc), .A0(A0),
    .HartStatus(HartStatus), .HartDone(HartDone), .RetiredCnt(RetiredCnt),
    .CycleCnt(CycleCnt), .TestDone(TestDone), .TestPass(TestPass),
    .TestTimeout(TestTimeout)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] a0);
    InstValid[h]           = 1'b1;
    Pc[32*h +: 32]          = pc;
    Instruction[32*h +: 32] = ins;
    A0[32*h +: 32]          = a0;
  endtask

  // One clock edge, sample point 1ns later, then drop all valids.
  task automatic tick();
    @(posedge Clock);
    #1;
    InstValid = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_status"}, 64'(HartStatus), 64'd0);
    check_val({tag, "_hdone"}, 64'(HartDone), 64'd0);
    check_val({tag, "_retired"}, 64'(RetiredCnt), 64'd0);
    check_val({tag, "_cycle"}, 64'(CycleCnt), 64'd0);
    check_val({tag, "_flags"}, 64'({TestDone, TestPass, TestTimeout}), 64'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_zero("rst");

    // A: hart0 five distinct PCs then ebreak a0=0; hart1 ebreak afterwards
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h100 + 32'(4 * i), NOP, 32'd0);
      tick();
    end
    drive(0, 32'h114, EBREAK, 32'd0);
    tick();
    check_val("a_status0", 64'(HartStatus), 64'h1);
    check_val("a_ret0", 64'(RetiredCnt[31:0]), 64'd6);
    check_val("a_hdone", 64'(HartDone), 64'h1);
    check_val("a_notdone", 64'(TestDone), 64'd0);
    drive(1, 32'h200, EBREAK, 32'd0);
    tick();
    check_val("a_status", 64'(HartStatus), 64'h5);
    check_val("a_flags", 64'({TestDone, TestPass, TestTimeout}), 64'b110);
    check_val("a_cycle", 64'(CycleCnt), 64'd7);
    // Frozen after done
    drive(0, 32'h300, ECALL, 32'd5);
    tick();
    check_val("a_frz_status", 64'(HartStatus), 64'h5);
    check_val("a_frz_cycle", 64'(CycleCnt), 64'd7);
    check_val("a_frz_ret0", 64'(RetiredCnt[31:0]), 64'd6);
    // Reset after TestDone
    do_reset();
    check_zero("rst_done");

    // B: hart1 pass, hart0 ecall with a0=5 -> fail
    drive(1, 32'h40, EBREAK, 32'd0);
    tick();
    drive(0, 32'h80, ECALL, 32'd5);
    tick();
    check_val("b_status", 64'(HartStatus), 64'h6);
    check_val("b_flags", 64'({TestDone, TestPass, TestTimeout}), 64'b100);
    check_val("b_ret", 64'(RetiredCnt), {32'd1, 32'd1});

    // C: hang detection with an interrupted run and InstValid gaps
    do_reset();
    drive(1, 32'h40, EBREAK, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h10, NOP, 32'd0);
      tick();
    end
    drive(0, 32'h14, NOP, 32'd0);
    tick();
    check_val("c_3rep_break", 64'(HartStatus), 64'h4);
    drive(0, 32'h14, NOP, 32'd0);
    tick();
    idle(1);
    drive(0, 32'h14, NOP, 32'd0);
    tick();
    idle(2);
    check_val("c_gap_run", 64'(HartStatus), 64'h4);
    drive(0, 32'h14, NOP, 32'd0);
    tick();
    check_val("c_hung", 64'(HartStatus), 64'h7);
    check_val("c_flags", 64'({TestDone, TestPass, TestTimeout}), 64'b100);
    check_val("c_ret0", 64'(RetiredCnt[31:0]), 64'd7);

    // C2: ebreak on the hang-threshold cycle -> pass
    do_reset();
    drive(1, 32'h40, EBREAK, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h20, NOP, 32'd0);
      tick();
    end
    drive(0, 32'h20, EBREAK, 32'd0);
    tick();
    check_val("c2_status", 64'(HartStatus), 64'h5);
    check_val("c2_pass", 64'({TestDone, TestPass, TestTimeout}), 64'b110);

    // D: timeout with hart0 passed at cycle 10, hart1 running
    do_reset();
    idle(9);
    drive(0, 32'h50, EBREAK, 32'd0);
    tick();
    check_val("d_cyc10", 64'(CycleCnt), 64'd10);
    idle(39);
    check_val("d_cyc49", 64'(CycleCnt), 64'd49);
    check_val("d_notdone", 64'(TestDone), 64'd0);
    tick();
    check_val("d_cyc50", 64'(CycleCnt), 64'd50);
    check_val("d_flags", 64'({TestDone, TestPass, TestTimeout}), 64'b101);
    check_val("d_status", 64'(HartStatus), 64'h1);
    drive(1, 32'h60, EBREAK, 32'd0);
    tick();
    idle(2);
    check_val("d_frz_cycle", 64'(CycleCnt), 64'd50);
    check_val("d_frz_status", 64'(HartStatus), 64'h1);
    check_val("d_frz_ret1", 64'(RetiredCnt[63:32]), 64'd0);

    // E: last hart terminates on the timeout edge
    do_reset();
    drive(0, 32'h50, EBREAK, 32'd0);
    tick();
    idle(48);
    check_val("e_cyc49", 64'(CycleCnt), 64'd49);
    drive(1, 32'h60, EBREAK, 32'd0);
    tick();
    check_val("e_flags", 64'({TestDone, TestPass, TestTimeout}), 64'b110);
    check_val("e_cyc50", 64'(CycleCnt), 64'd50);
    check_val("e_status", 64'(HartStatus), 64'h5);

    // F: PC 0 right after reset, Enable low holds everything, then mid-run reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'h0, NOP, 32'd0);
      tick();
    end
    check_val("f_first_pc0", 64'(HartStatus), 64'h0);
    Enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 32'h0, NOP, 32'd0);
      tick();
    end
    check_val("f_en_cycle", 64'(CycleCnt), 64'd3);
    check_val("f_en_ret0", 64'(RetiredCnt[31:0]), 64'd3);
    check_val("f_en_status", 64'(HartStatus), 64'h0);
    Enable = 1'b1;
    drive(0, 32'h0, NOP, 32'd0);
    tick();
    check_val("f_hung", 64'(HartStatus), 64'h3);
    check_val("f_ret0", 64'(RetiredCnt[31:0]), 64'd4);
    drive(0, 32'h4, NOP, 32'd0);
    tick();
    check_val("f_ret0_stop", 64'(RetiredCnt[31:0]), 64'd4);
    check_val("f_cycle", 64'(CycleCnt), 64'd5);
    do_reset();
    check_zero("rst_mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rvc_asap_eot_monitor.md
Name: rvc_asap_eot_monitor

Overview:
Synthesizable, parametrised end-of-test monitor for rvc_asap simulation and FPGA bring-up. It supports NUM_HARTS cores and watches each core's executed-instruction stream. Per hart it detects termination opcodes (ebreak/ecall), self-loop hangs, and a global cycle timeout. It counts cycles and retired instructions, and reports a per-hart and global pass/fail verdict that the bench or an FPGA LED/UART path can sample.

Parameters:
NUM_HARTS, 1, number of monitored harts (1..8)
CNT_W, 32, width of the cycle counter
TIMEOUT_CYCLES, 10000, enabled cycles before a global timeout (must be < 2^CNT_W)
HANG_CYCLES, 256, consecutive valid same-PC cycles that declare a hart hung (>=2)
EBREAK_OP, 32'h00100073, terminating opcode 1
ECALL_OP, 32'h00000073, terminating opcode 2

Ports:
Clock  in  1  core clock
Rst  in  1  synchronous, active-high reset
Enable  in  1  monitor runs when high; all state holds when low
InstValid  in  NUM_HARTS  bit h: Instruction/Pc of hart h valid this cycle
Instruction  in  32*NUM_HARTS  hart h at [32h+31:32h]
Pc  in  32*NUM_HARTS  PC of the instruction, same packing
A0  in  32*NUM_HARTS  current x10 value of hart h, same packing
HartStatus  out  2*NUM_HARTS  per hart: 00 running, 01 pass, 10 fail, 11 hung
HartDone  out  NUM_HARTS  HartStatus != 00
RetiredCnt  out  32*NUM_HARTS  valid instructions accepted per hart, saturating
CycleCnt  out  CNT_W  enabled cycles since reset, saturating
TestDone  out  1  all harts done, or timeout
TestPass  out  1  TestDone, no timeout, and every HartStatus == 01
TestTimeout  out  1  CycleCnt reached TIMEOUT_CYCLES before all harts finished

Behaviour:
- Reset: every output is 0. Internal last-PC registers and hang counters are 0. Per-hart FSMs are in RUN.
- Rst wins over everything. Asserting it mid-test clears all state at the next rising edge, including after TestDone.
- Per-hart FSM states: RUN, PASS, FAIL, HUNG. PASS, FAIL and HUNG are sticky until Rst.
- RUN to PASS/FAIL: on a cycle with Enable & InstValid[h] & Instruction == EBREAK_OP or ECALL_OP:
  - A0 == 0 gives PASS; any other A0 gives FAIL.
  - The terminating instruction is counted in RetiredCnt.
  - HartStatus updates at the next edge (1-cycle latency).
- Hang detection, per hart, counted only on Enable & InstValid[h] cycles:
  - Pc equal to the last valid Pc: hang counter +1.
  - Pc different: counter resets to 0 and the last-valid-Pc register is reloaded.
  - When the counter would reach HANG_CYCLES-1, the FSM goes RUN to HUNG at that edge. HANG_CYCLES identical valid PCs in a row therefore declare a hang.
  - The hang counter is only meaningful after the first valid PC following reset. The first valid instruction never counts as a repeat.
- Priority within one hart in one cycle: a terminating opcode beats the hang threshold.
- InstValid low: the hart's counters and last-PC hold; this is not a hang.
- RetiredCnt[h]: +1 per Enable & InstValid[h] cycle while the hart is in RUN. It saturates at 32'hFFFFFFFF and stops counting once the hart leaves RUN.
- CycleCnt: +1 per Enable cycle while TestDone == 0. It saturates at all-ones and freezes when TestDone is set.
- Timeout: at the edge where CycleCnt becomes TIMEOUT_CYCLES with any hart still in RUN, TestTimeout and TestDone are set. Harts in RUN stay 00.
- TestDone = registered (all HartDone) | TestTimeout. Once set, no FSM, counter or status changes until Rst. The whole monitor freezes.
- Simultaneous events: if the last hart terminates on the same edge the timeout would fire, termination wins and TestTimeout stays 0.
- TestPass is registered. It is valid whenever TestDone == 1 and is 0 whenever TestDone == 0.
- Enable low: all state holds, including an in-progress hang count.
- Unused upper bits of packed inputs are ignored; no X-propagation from harts with InstValid low.

Test Plan:
- NUM_HARTS=1: 5 valid instructions with distinct PCs, then EBREAK_OP with A0=0 -> one cycle later HartStatus=01, TestDone=1, TestPass=1, RetiredCnt=6.
- NUM_HARTS=1: ECALL_OP with A0=32'h5 -> HartStatus=10, TestDone=1, TestPass=0, TestTimeout=0.
- HANG_CYCLES=4: Pc 0x10 held valid for 4 cycles -> HUNG (11) after the 4th valid cycle. With 3 repeats then Pc 0x14 -> still 00. Gaps in InstValid between repeats -> still HUNG only after 4 valid repeats.
- NUM_HARTS=2, TIMEOUT_CYCLES=50: hart0 ebreak A0=0 at cycle 10, hart1 never terminates -> at CycleCnt=50 TestTimeout=1, TestDone=1, TestPass=0, HartStatus={00,01}. CycleCnt frozen at 50 afterwards.
- Simultaneity: hart1 terminates with A0=0 on the exact timeout edge -> TestTimeout=0, TestPass=1. Ebreak on the hang-threshold cycle -> PASS, not HUNG.
- Rst pulsed one cycle mid-run and again after TestDone -> all outputs 0 at the next edge. Enable held low for 20 cycles -> CycleCnt, RetiredCnt and hang counters unchanged.
